// File: rtl/onehot_reg_file.sv
// 8 x DW register file loaded by a one-hot decoder vector, with two registered
// read ports, write-through bypass, sticky multi-hot error flag and write counter.
module onehot_reg_file #(
    parameter int DW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    W_Load,
    input  logic [DW-1:0] W_Data,
    input  logic [2:0]    S_Adr,
    input  logic [2:0]    T_Adr,
    input  logic          err_clr,
    output logic [DW-1:0] S,
    output logic [DW-1:0] T,
    output logic          load_err,
    output logic [CW-1:0] wr_count
);

    logic [DW-1:0] regs [8];
    logic [3:0]    load_ones;
    logic          load_onehot;
    logic          load_multi;
    logic          byp_s;
    logic          byp_t;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    always_comb begin
        load_ones   = count_ones(W_Load);
        load_onehot = (load_ones == 4'd1);
        load_multi  = (load_ones >= 4'd2);
        // Bypass only when this edge really writes the addressed register.
        byp_s       = load_onehot && W_Load[S_Adr];
        byp_t       = load_onehot && W_Load[T_Adr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            S        <= '0;
            T        <= '0;
            load_err <= 1'b0;
            wr_count <= '0;
        end else begin
            if (load_onehot) begin
                for (int i = 0; i < 8; i++) begin
                    if (W_Load[i]) begin
                        regs[i] <= W_Data;
                    end
                end
                wr_count <= wr_count + {{(CW-1){1'b0}}, 1'b1};
            end

            S <= byp_s ? W_Data : regs[S_Adr];
            T <= byp_t ? W_Data : regs[T_Adr];

            // Setting the flag takes priority over a simultaneous clear.
            if (load_multi) begin
                load_err <= 1'b1;
            end else if (err_clr) begin
                load_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_reg_file.sv
// Directed self-checking bench for onehot_reg_file using immediate assertions.
module tb_onehot_reg_file;

    logic        clk;
    logic        reset;
    logic [7:0]  W_Load;
    logic [15:0] W_Data;
    logic [2:0]  S_Adr;
    logic [2:0]  T_Adr;
    logic        err_clr;
    logic [15:0] S;
    logic [15:0] T;
    logic        load_err;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;

    onehot_reg_file #(.DW(16), .CW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .W_Load   (W_Load),
        .W_Data   (W_Data),
        .S_Adr    (S_Adr),
        .T_Adr    (T_Adr),
        .err_clr  (err_clr),
        .S        (S),
        .T        (T),
        .load_err (load_err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        W_Load  = 8'h00;
        W_Data  = 16'h0000;
        S_Adr   = 3'd0;
        T_Adr   = 3'd0;
        err_clr = 1'b0;
        step();
        step();
        chk("rst_S", {16'h0, S}, 32'h0);
        chk("rst_T", {16'h0, T}, 32'h0);
        chk("rst_err", {31'h0, load_err}, 32'h0);
        chk("rst_cnt", {24'h0, wr_count}, 32'h0);
        reset = 1'b0;

        // Write R[i] = 0x1100 + i.
        for (int i = 0; i < 8; i++) begin
            W_Load = 8'h01 << i;
            W_Data = 16'h1100 + 16'(i);
            step();
        end
        W_Load = 8'h00;
        chk("wr_count_8", {24'h0, wr_count}, 32'd8);

        // Sweep reads; data appears one edge after the address.
        for (int i = 0; i < 8; i++) begin
            S_Adr = 3'(i);
            T_Adr = 3'(7 - i);
            step();
            chk("sweep_S", {16'h0, S}, 32'h1100 + 32'(i));
            chk("sweep_T", {16'h0, T}, 32'h1107 - 32'(i));
        end

        // Write-through bypass on S, old data on T.
        W_Load = 8'h20;
        W_Data = 16'hA5A5;
        S_Adr  = 3'd5;
        T_Adr  = 3'd4;
        step();
        chk("byp_S", {16'h0, S}, 32'hA5A5);
        chk("byp_T", {16'h0, T}, 32'h1104);
        chk("byp_cnt", {24'h0, wr_count}, 32'd9);
        W_Load = 8'h00;
        W_Data = 16'h0000;
        T_Adr  = 3'd5;
        step();
        chk("r5_S", {16'h0, S}, 32'hA5A5);
        chk("r5_same_T", {16'h0, T}, 32'hA5A5);

        // Multi-hot: R1=1, R2=2 then illegal 0x06 write.
        W_Load = 8'h02; W_Data = 16'h0001; step();
        W_Load = 8'h04; W_Data = 16'h0002; step();
        chk("pre_multi_cnt", {24'h0, wr_count}, 32'd11);
        W_Load = 8'h06;
        W_Data = 16'hFFFF;
        S_Adr  = 3'd1;
        T_Adr  = 3'd2;
        step();
        chk("multi_err", {31'h0, load_err}, 32'h1);
        chk("multi_cnt", {24'h0, wr_count}, 32'd11);
        chk("multi_nobyp_S", {16'h0, S}, 32'h0001);
        chk("multi_nobyp_T", {16'h0, T}, 32'h0002);
        W_Load = 8'h00;
        step();
        chk("multi_R1", {16'h0, S}, 32'h0001);
        chk("multi_R2", {16'h0, T}, 32'h0002);
        chk("err_sticky", {31'h0, load_err}, 32'h1);

        // Clear vs set priority.
        err_clr = 1'b1;
        W_Load  = 8'h81;
        step();
        chk("clr_set_wins", {31'h0, load_err}, 32'h1);
        chk("clr_set_cnt", {24'h0, wr_count}, 32'd11);
        W_Load = 8'h00;
        step();
        chk("clr_done", {31'h0, load_err}, 32'h0);
        err_clr = 1'b0;

        // Asynchronous reset with R3=BEEF and load_err set.
        W_Load = 8'h08; W_Data = 16'hBEEF; S_Adr = 3'd3; T_Adr = 3'd3; step();
        W_Load = 8'h03; step();
        W_Load = 8'h00; step();
        chk("pre_rst_S", {16'h0, S}, 32'hBEEF);
        chk("pre_rst_err", {31'h0, load_err}, 32'h1);
        chk("pre_rst_cnt", {24'h0, wr_count}, 32'd12);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_S", {16'h0, S}, 32'h0);
        chk("arst_T", {16'h0, T}, 32'h0);
        chk("arst_err", {31'h0, load_err}, 32'h0);
        chk("arst_cnt", {24'h0, wr_count}, 32'h0);
        reset = 1'b0;
        step();
        chk("arst_R3", {16'h0, S}, 32'h0);

        // Counter wrap with interleaved zero-vector cycles.
        for (int j = 0; j < 255; j++) begin
            W_Load = 8'h01 << (j % 8);
            W_Data = 16'(j);
            step();
            W_Load = 8'h00;
            step();
        end
        chk("cnt_255", {24'h0, wr_count}, 32'd255);
        W_Load = 8'h80;
        W_Data = 16'h00FF;
        step();
        chk("cnt_wrap", {24'h0, wr_count}, 32'd0);
        W_Load = 8'h00;
        S_Adr  = 3'd7;
        T_Adr  = 3'd6;
        step();
        chk("wrap_hold", {24'h0, wr_count}, 32'd0);
        chk("wrap_R7", {16'h0, S}, 32'h00FF);
        chk("wrap_R6", {16'h0, T}, 32'h00FE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onehot_reg_file.md
Name: onehot_reg_file

Overview:
- 8 x 16-bit register file sitting directly downstream of the 3-to-8 write-address decoder.
- Consumes the decoder's one-hot 8-bit output as per-register load enables; provides two registered read ports (S, T) for the datapath/ALU.
- Rejects illegal (multi-hot) load vectors: no write occurs and a sticky error flag is set.
- Counts accepted writes for debug.

Parameters:
- DW, 16, data width of each register and of the read/write ports
- CW, 8, width of the accepted-write counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- W_Load  input  8  one-hot load vector from decoder Y; bit i loads register Ri; all-zero means no write
- W_Data  input  DW  write data
- S_Adr  input  3  read address, port S
- T_Adr  input  3  read address, port T
- err_clr  input  1  synchronous clear of load_err
- S  output  DW  registered read data, port S
- T  output  DW  registered read data, port T
- load_err  output  1  sticky flag: a multi-hot W_Load was presented
- wr_count  output  CW  number of accepted writes, wraps modulo 2^CW

Behaviour:
- Reset (asynchronous, reset=1): R0..R7=0, S=0, T=0, load_err=0, wr_count=0. State is held at these values while reset=1; operation resumes on the first rising clk edge after deassertion.
- W_Load classification, evaluated each clk edge:
  - zero: W_Load==8'h00.
  - onehot: exactly one bit set.
  - multihot: two or more bits set.
- Write:
  - onehot: Ri<=W_Data for the single set bit i; wr_count<=wr_count+1, wrapping 2^CW-1 -> 0.
  - zero: no register change, wr_count holds.
  - multihot: no register changes (write fully suppressed, including partial writes), wr_count holds, load_err<=1.
- load_err:
  - Set by multihot; cleared by err_clr=1.
  - If multihot and err_clr occur on the same edge, set wins (load_err=1).
  - Otherwise holds.
- Read, 1-cycle latency: on each edge, S<=R[S_Adr] and T<=R[T_Adr].
- Write-through bypass: if the same edge performs an onehot write to register k and S_Adr==k (or T_Adr==k), that port loads W_Data rather than the old Rk. No bypass on zero or multihot cycles.
- Read-port independence: S_Adr==T_Adr is legal; both ports return identical data.
- No handshake: one write and two reads may occur on every cycle, back to back.
- Reset mid-operation: an in-flight write on the same edge as reset assertion is lost; all state goes to reset values immediately, without waiting for clk.

Test Plan:
- Reset: assert reset asynchronously between edges with R3=16'hBEEF -> S, T, load_err, wr_count go to 0 without a clk edge; after release, reading S_Adr=3 returns 16'h0000.
- Write/read all: write R[i]=16'h1100+i using W_Load=1<<i for i=0..7, then sweep S_Adr=i, T_Adr=7-i -> S=16'h1100+i and T=16'h1107-i, each one cycle after the address is applied; wr_count=8.
- Bypass: W_Load=8'h20, W_Data=16'hA5A5, S_Adr=5, T_Adr=4 on the same edge -> after that edge S=16'hA5A5 and T=old R4.
- Multihot: with R1=16'h0001 and R2=16'h0002, apply W_Load=8'h06, W_Data=16'hFFFF -> R1 and R2 unchanged, load_err=1, wr_count unchanged; a following zero-vector cycle leaves load_err=1.
- Error clear priority: err_clr=1 together with W_Load=8'h81 -> load_err stays 1; next cycle err_clr=1 with W_Load=8'h00 -> load_err=0.
- Counter wrap: with CW=8, perform 256 onehot writes -> wr_count returns to 8'h00; zero-vector cycles interleaved do not advance the count.
